// File: rtl/la_pkg.sv
// Shared logic-analyzer definitions used by both the capture side and the
// VGA display path: FSM state encoding, default buffer geometry, and a helper
// for sizing the sample counters.
package la_pkg;

    localparam int LA_CHANNEL_COUNT    = 10;
    localparam int LA_SAMPLE_BUFF_SIZE = 160;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PREFILL = 3'd1,
        ST_ARMED   = 3'd2,
        ST_POST    = 3'd3,
        ST_DONE    = 3'd4
    } la_state_t;

    // Counter width able to hold every value from 0 up to depth inclusive.
    function automatic int la_count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Sample-rate divider: produces a one-cycle tick every sample_div+1 cycles
// while run is high. The >= compare lets a lowered sample_div take effect
// immediately instead of waiting for the counter to wrap.
module sample_tick_gen
    import la_pkg::*;
#(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run,
    input  logic                 clear,
    input  logic [DIV_WIDTH-1:0] sample_div,
    output logic                 tick
);

    logic [DIV_WIDTH-1:0] div_cnt;

    assign tick = run && !clear && (div_cnt >= sample_div);

    // Divider counter: restarts on clear, on every tick, and while stopped.
    always_ff @(posedge clk) begin
        if (!reset) begin
            div_cnt <= '0;
        end else if (clear || !run || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sample_capture.sv
// Writer side of the logic-analyzer sample buffers. Samples the probe
// channels at the divided rate, waits for a trigger edge on the selected
// channel, and drives the shared shift/s_in strobe of the per-channel buffers
// through pre-trigger and post-trigger fill before freezing them in DONE.
// Build option: define LA_INPUT_SYNC_EN to put a 2-flop synchroniser on
// chan_in (adds 2 clk of input-to-s_in latency); leave it undefined only when
// chan_in is already in the clk domain.
module sample_capture
    import la_pkg::*;
#(
    parameter int CHANNEL_COUNT     = LA_CHANNEL_COUNT,
    parameter int SAMPLE_BUFF_SIZE  = LA_SAMPLE_BUFF_SIZE,
    parameter int POST_TRIG_SAMPLES = 80,
    parameter int DIV_WIDTH         = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [CHANNEL_COUNT-1:0]         chan_in,
    input  logic [CHANNEL_COUNT-1:0]         chan_enable,
    input  logic [DIV_WIDTH-1:0]             sample_div,
    input  logic [$clog2(CHANNEL_COUNT)-1:0] trig_chan,
    input  logic                             trig_rising,
    input  logic                             arm,
    output logic                             shift,
    output logic [CHANNEL_COUNT-1:0]         s_in,
    output logic                             armed,
    output logic                             done
);

    localparam int CNT_WIDTH  = la_count_width(SAMPLE_BUFF_SIZE);
    localparam int TRIG_WIDTH = $clog2(CHANNEL_COUNT);
    localparam logic [CNT_WIDTH-1:0] PRE_SAMPLES  = CNT_WIDTH'(SAMPLE_BUFF_SIZE - POST_TRIG_SAMPLES);
    localparam logic [CNT_WIDTH-1:0] POST_SAMPLES = CNT_WIDTH'(POST_TRIG_SAMPLES);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE      = CNT_WIDTH'(1);

    la_state_t                state;
    logic [CNT_WIDTH-1:0]     pre_cnt;
    logic [CNT_WIDTH-1:0]     post_cnt;
    logic [CHANNEL_COUNT-1:0] chan_sync;
    logic [CHANNEL_COUNT-1:0] smp;
    logic                     prev;
    logic                     cur_bit;
    logic                     raw_bit;
    logic                     trig_en;
    logic                     trig;
    logic                     run;
    logic                     tick;

`ifdef LA_INPUT_SYNC_EN
    logic [CHANNEL_COUNT-1:0] sync_meta;
    logic [CHANNEL_COUNT-1:0] sync_out;

    // Two-flop synchroniser bringing the asynchronous probe pins into clk.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_meta <= '0;
            sync_out  <= '0;
        end else begin
            sync_meta <= chan_in;
            sync_out  <= sync_meta;
        end
    end

    assign chan_sync = sync_out;
`else
    assign chan_sync = chan_in;
`endif

    assign smp = chan_sync & chan_enable;
    assign run = (state == ST_PREFILL) || (state == ST_ARMED) || (state == ST_POST);

    // Pick the trigger channel; an index past the last channel selects nothing.
    always_comb begin
        cur_bit = 1'b0;
        raw_bit = 1'b0;
        trig_en = 1'b0;
        for (int i = 0; i < CHANNEL_COUNT; i++) begin
            if (trig_chan == TRIG_WIDTH'(i)) begin
                cur_bit = smp[i];
                raw_bit = chan_sync[i];
                trig_en = chan_enable[i];
            end
        end
    end

    assign trig = trig_en && (trig_rising ? (!prev && cur_bit) : (prev && !cur_bit));

    sample_tick_gen #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_tick_gen (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .clear      (arm),
        .sample_div (sample_div),
        .tick       (tick)
    );

    // Capture FSM with registered shift strobe, sample data and status flags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= ST_IDLE;
            pre_cnt  <= '0;
            post_cnt <= '0;
            prev     <= 1'b0;
            shift    <= 1'b0;
            s_in     <= '0;
            armed    <= 1'b0;
            done     <= 1'b0;
        end else begin
            shift <= 1'b0;
            if (arm) begin
                pre_cnt  <= '0;
                post_cnt <= '0;
                prev     <= raw_bit;
                armed    <= 1'b1;
                done     <= 1'b0;
                state    <= (PRE_SAMPLES == '0) ? ST_ARMED : ST_PREFILL;
            end else if (tick) begin
                shift <= 1'b1;
                s_in  <= smp;
                prev  <= cur_bit;
                case (state)
                    ST_PREFILL: begin
                        pre_cnt <= pre_cnt + 1'b1;
                        if (pre_cnt + 1'b1 == PRE_SAMPLES) begin
                            state <= ST_ARMED;
                        end
                    end
                    ST_ARMED: begin
                        if (trig) begin
                            post_cnt <= CNT_ONE;
                            armed    <= 1'b0;
                            if (POST_SAMPLES == CNT_ONE) begin
                                state <= ST_DONE;
                                done  <= 1'b1;
                            end else begin
                                state <= ST_POST;
                            end
                        end
                    end
                    ST_POST: begin
                        post_cnt <= post_cnt + 1'b1;
                        if (post_cnt + 1'b1 == POST_SAMPLES) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sample_capture.sv
// Self-checking bench for sample_capture with default geometry
// (10 channels, 160-deep buffers, 80 post-trigger samples). Expected s_in
// values are queued as each stimulus is driven and compared as shifts appear.
module tb_sample_capture;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  chan_in;
    logic [9:0]  chan_enable;
    logic [15:0] sample_div;
    logic [3:0]  trig_chan;
    logic        trig_rising;
    logic        arm;
    logic        shift;
    logic [9:0]  s_in;
    logic        armed;
    logic        done;

    typedef struct {
        logic [9:0] chan;
        logic [9:0] en;
        logic [9:0] exp;
    } vec_t;

    vec_t       vecs [8];
    logic [9:0] exp_q [$];
    int         tests_run    = 0;
    int         tests_failed = 0;
    int         shift_cnt    = 0;
    bit         sb_on        = 1'b1;

    sample_capture dut (
        .clk         (clk),
        .reset       (reset),
        .chan_in     (chan_in),
        .chan_enable (chan_enable),
        .sample_div  (sample_div),
        .trig_chan   (trig_chan),
        .trig_rising (trig_rising),
        .arm         (arm),
        .shift       (shift),
        .s_in        (s_in),
        .armed       (armed),
        .done        (done)
    );

    // Free-running 100 MHz style clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic applyStimulus(input logic [9:0] c, input logic [9:0] en);
        chan_in     = c;
        chan_enable = en;
    endtask

    // One clock, sampled 1 time unit after the edge; any shift is scored.
    task automatic stepClock();
        logic [9:0] e;
        @(posedge clk);
        #1;
        if (shift === 1'b1) begin
            shift_cnt++;
            if (sb_on) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_shift", 32'(shift), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("s_in", 32'(s_in), 32'(e));
                end
            end
        end
    endtask

    task automatic waitShift(output int waited);
        waited = 0;
        for (int i = 0; i < 40; i++) begin
            stepClock();
            waited++;
            if (shift === 1'b1) break;
        end
        if (shift !== 1'b1) checkOutput("shift_timeout", 32'(shift), 32'd1);
    endtask

    task automatic pulseArm();
        arm = 1'b1;
        stepClock();
        arm = 1'b0;
    endtask

    initial begin
        int         w;
        int         base;
        int         lat;
        logic [9:0] c;

        vecs[0] = '{10'h3FF, 10'h3FF, 10'h3FF};
        vecs[1] = '{10'h000, 10'h3FF, 10'h000};
        vecs[2] = '{10'h2AA, 10'h3FF, 10'h2AA};
        vecs[3] = '{10'h155, 10'h0F0, 10'h050};
        vecs[4] = '{10'h3FF, 10'h300, 10'h300};
        vecs[5] = '{10'h1C3, 10'h3FF, 10'h1C3};
        vecs[6] = '{10'h0F0, 10'h0FF, 10'h0F0};
        vecs[7] = '{10'h204, 10'h3FB, 10'h200};

        reset       = 1'b0;
        arm         = 1'b1;
        chan_in     = '0;
        chan_enable = '0;
        sample_div  = '0;
        trig_chan   = 4'd2;
        trig_rising = 1'b1;

        // Reset held with arm asserted.
        repeat (3) stepClock();
        checkOutput("reset_shift", 32'(shift), 32'd0);
        checkOutput("reset_s_in", 32'(s_in), 32'd0);
        checkOutput("reset_armed", 32'(armed), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        arm   = 1'b0;
        reset = 1'b1;
        repeat (3) stepClock();
        checkOutput("idle_armed", 32'(armed), 32'd0);
        checkOutput("idle_done", 32'(done), 32'd0);
        checkOutput("idle_shift", 32'(shift), 32'd0);

        // Pre-trigger fill through the vector table, falling trigger selected.
        sample_div  = 16'd3;
        trig_rising = 1'b0;
        applyStimulus(vecs[0].chan, vecs[0].en);
        repeat (3) stepClock();
        pulseArm();
        checkOutput("armed_after_arm", 32'(armed), 32'd1);
        for (int k = 0; k < 80; k++) begin
            exp_q.push_back(vecs[k % 8].exp);
            waitShift(w);
            checkOutput("shift_period", 32'(w), 32'd4);
            if (k < 79) applyStimulus(vecs[(k + 1) % 8].chan, vecs[(k + 1) % 8].en);
        end
        applyStimulus(10'h001, 10'h3FF);
        trig_rising = 1'b1;
        for (int k = 0; k < 5; k++) begin
            exp_q.push_back(10'h001);
            waitShift(w);
        end
        checkOutput("armed_steady", 32'(armed), 32'd1);
        checkOutput("no_done_armed", 32'(done), 32'd0);

        // Rising trigger on channel 2, then 80 post-trigger shifts.
        applyStimulus(10'h004, 10'h3FF);
        exp_q.push_back(10'h004);
        waitShift(w);
        checkOutput("armed_in_post", 32'(armed), 32'd0);
        checkOutput("done_in_post", 32'(done), 32'd0);
        for (int j = 2; j <= 80; j++) begin
            exp_q.push_back(10'h004);
            waitShift(w);
            if (j == 79) checkOutput("done_before_last", 32'(done), 32'd0);
        end
        checkOutput("done_after_post", 32'(done), 32'd1);
        checkOutput("armed_in_done", 32'(armed), 32'd0);
        base = shift_cnt;
        repeat (20) stepClock();
        checkOutput("no_shift_in_done", 32'(shift_cnt - base), 32'd0);
        checkOutput("s_in_hold_done", 32'(s_in), 32'h004);

        // Re-arm from DONE with trigger channel disabled.
        applyStimulus(10'h000, 10'h3FB);
        pulseArm();
        checkOutput("rearm_armed", 32'(armed), 32'd1);
        checkOutput("rearm_done", 32'(done), 32'd0);
        for (int k = 0; k < 80; k++) begin
            exp_q.push_back(10'h000);
            waitShift(w);
        end
        for (int k = 0; k < 10; k++) begin
            c = (k % 2 == 0) ? 10'h004 : 10'h000;
            applyStimulus(c, 10'h3FB);
            exp_q.push_back(10'h000);
            waitShift(w);
        end
        checkOutput("disabled_armed", 32'(armed), 32'd1);
        checkOutput("disabled_done", 32'(done), 32'd0);

        // Out-of-range trigger channel.
        trig_chan = 4'd12;
        for (int k = 0; k < 10; k++) begin
            c = (k % 2 == 0) ? 10'h004 : 10'h000;
            applyStimulus(c, 10'h3FF);
            exp_q.push_back(c);
            waitShift(w);
        end
        checkOutput("invalid_armed", 32'(armed), 32'd1);
        checkOutput("invalid_done", 32'(done), 32'd0);

        // arm coinciding with a trigger tick restarts the pre-fill.
        trig_chan = 4'd2;
        applyStimulus(10'h004, 10'h3FF);
        repeat (3) stepClock();
        arm = 1'b1;
        stepClock();
        arm = 1'b0;
        checkOutput("shift_on_arm", 32'(shift), 32'd0);
        checkOutput("arm_wins_armed", 32'(armed), 32'd1);
        checkOutput("arm_wins_done", 32'(done), 32'd0);
        exp_q.push_back(10'h004);
        waitShift(w);
        for (int n = 2; n <= 160; n++) begin
            c = (n <= 78) ? 10'h000 : (n == 79) ? 10'h004 : (n == 80) ? 10'h000 : 10'h004;
            applyStimulus(c, 10'h3FF);
            exp_q.push_back(c);
            waitShift(w);
            if (n == 80)  checkOutput("restart_still_armed", 32'(armed), 32'd1);
            if (n == 81)  checkOutput("restart_triggered", 32'(armed), 32'd0);
            if (n == 159) checkOutput("restart_done_early", 32'(done), 32'd0);
        end
        checkOutput("restart_done", 32'(done), 32'd1);

        // Lowering sample_div mid-count takes effect immediately.
        sample_div = 16'd100;
        applyStimulus(10'h3FF, 10'h3FF);
        pulseArm();
        base = shift_cnt;
        repeat (50) stepClock();
        checkOutput("slow_no_shift", 32'(shift_cnt - base), 32'd0);
        sample_div = 16'd2;
        exp_q.push_back(10'h3FF);
        stepClock();
        checkOutput("lowered_first_tick", 32'(shift), 32'd1);
        stepClock();
        checkOutput("lowered_gap1", 32'(shift), 32'd0);
        stepClock();
        checkOutput("lowered_gap2", 32'(shift), 32'd0);
        exp_q.push_back(10'h3FF);
        stepClock();
        checkOutput("lowered_second_tick", 32'(shift), 32'd1);

        // Input-to-s_in latency with a tick every cycle.
        sb_on      = 1'b0;
        sample_div = 16'd0;
        applyStimulus(10'h0AA, 10'h3FF);
        repeat (5) stepClock();
        checkOutput("s_in_before_change", 32'(s_in), 32'h0AA);
        applyStimulus(10'h155, 10'h3FF);
        lat = 0;
        for (int i = 0; (i < 10) && (s_in !== 10'h155); i++) begin
            stepClock();
            lat++;
        end
`ifdef LA_INPUT_SYNC_EN
        checkOutput("input_latency", 32'(lat), 32'd3);
`else
        checkOutput("input_latency", 32'(lat), 32'd1);
`endif

        // Reset in the middle of a capture.
        reset = 1'b0;
        stepClock();
        checkOutput("midreset_shift", 32'(shift), 32'd0);
        checkOutput("midreset_s_in", 32'(s_in), 32'd0);
        checkOutput("midreset_armed", 32'(armed), 32'd0);
        checkOutput("midreset_done", 32'(done), 32'd0);
        reset = 1'b1;
        sb_on = 1'b1;
        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
